// File: rtl/digit_splitter_pkg.sv
// Shared types and constants for the binary-to-decimal digit splitter.
// DIGIT_SPLITTER_LZ_BLANK_EN enables leading-zero suppression in the top.
package digit_splitter_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    localparam int         BCD_W       = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam int         POS_W       = 3;

endpackage

// File: rtl/digit_splitter_bcd_add3.sv
// Double-dabble nibble corrector: values of 5 and above get +3 before the shift.
// Purely combinational; one instance per BCD digit.
module digit_splitter_bcd_add3
    import digit_splitter_pkg::*;
(
    input  logic [BCD_W-1:0] i_nib,
    output logic [BCD_W-1:0] o_nib
);

    assign o_nib = (i_nib >= ADD3_THRESH) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/digit_splitter.sv
// Streams the decimal digits of a binary value, MSB first, via double-dabble.
// DIGIT_SPLITTER_LZ_BLANK_EN: start at the highest nonzero digit.
module digit_splitter
    import digit_splitter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_DIGITS = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] value,
    input  logic             value_valid,
    output logic             value_ready,
    output logic [BCD_W-1:0] digit,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic [POS_W-1:0] digit_pos,
    output logic             digit_last,
    output logic             busy
);

    localparam int NB    = NUM_DIGITS * BCD_W;
    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [NB-1:0]    r_bcd;
    logic [CNT_W-1:0] r_count;
    logic [POS_W-1:0] r_pos;
    logic [BCD_W-1:0] r_digit;
    logic             r_valid;
    logic             r_last;
    logic             r_busy;

    logic [NB-1:0]                       w_adj;
    logic [NB-1:0]                       w_bcd_nx;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]    w_nib;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]    w_nx_nib;
    logic [POS_W-1:0]                    w_start;
    logic [POS_W-1:0]                    w_pos_dn;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_add3
        digit_splitter_bcd_add3 u_add3 (
            .i_nib (r_bcd[gi*BCD_W +: BCD_W]),
            .o_nib (w_adj[gi*BCD_W +: BCD_W])
        );
    end

    // The top bit of the top nibble falls off; it is zero for a valid sizing.
    assign w_bcd_nx = NB'({w_adj, r_shift[WIDTH-1]});
    assign w_nib    = r_bcd;
    assign w_nx_nib = w_bcd_nx;
    assign w_pos_dn = r_pos - POS_W'(1);

    always_comb begin
        w_start = '0;
`ifdef DIGIT_SPLITTER_LZ_BLANK_EN
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_nx_nib[i] != '0) w_start = POS_W'(i);
        end
`else
        w_start = POS_W'(NUM_DIGITS - 1);
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bcd   <= '0;
            r_count <= '0;
            r_pos   <= '0;
            r_digit <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (value_valid) begin
                        r_shift <= value;
                        r_bcd   <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_bcd   <= w_bcd_nx;
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_EMIT;
                        r_pos   <= w_start;
                        r_digit <= w_nx_nib[w_start];
                        r_valid <= 1'b1;
                        r_last  <= (w_start == '0);
                    end
                end
                S_EMIT: begin
                    if (digit_ready) begin
                        if (r_last) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_pos   <= w_pos_dn;
                            r_digit <= w_nib[w_pos_dn];
                            r_last  <= (w_pos_dn == '0);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign value_ready = (r_state == S_IDLE);
    assign digit       = r_digit;
    assign digit_valid = r_valid;
    assign digit_pos   = r_pos;
    assign digit_last  = r_last;
    assign busy        = r_busy;

endmodule

// File: tb/tb_digit_splitter.sv
// Directed bench for digit_splitter; expectations follow the
// DIGIT_SPLITTER_LZ_BLANK_EN setting of the build.
module tb_digit_splitter;

    logic        clock;
    logic        reset_n;
    logic [15:0] value;
    logic        value_valid;
    logic        value_ready;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        digit_ready;
    logic [2:0]  digit_pos;
    logic        digit_last;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    digit_splitter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit_pos   (digit_pos),
        .digit_last  (digit_last),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input int v);
        int n = 0;
        value       = 16'(v);
        value_valid = 1'b1;
        while (!value_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("send_wait", int'(n < 100), 1);
        @(posedge clock); #1;
        value_valid = 1'b0;
    endtask

    // Collects n of tot digits; optional 1/0 ready toggling checks stall hold.
    task automatic recv(input string tag, input int e[5], input int tot,
                        input int n, input bit stall, input int lat);
        int k = 0;
        int cyc = 0;
        int first = -1;
        bit tog = 1'b1;
        bit hold = 1'b0;
        int hd = 0;
        int hp = 0;
        int hl = 0;
        digit_ready = 1'b0;
        while (k < n && cyc < 300) begin
            if (digit_valid && first < 0) first = cyc;
            if (hold && digit_valid) begin
                check($sformatf("%s_hold_d%0d", tag, k), int'(digit), hd);
                check($sformatf("%s_hold_p%0d", tag, k), int'(digit_pos), hp);
                check($sformatf("%s_hold_l%0d", tag, k), int'(digit_last), hl);
                hold = 1'b0;
            end
            digit_ready = stall ? tog : 1'b1;
            tog = !tog;
            if (digit_valid) begin
                if (digit_ready) begin
                    check($sformatf("%s_d%0d", tag, k), int'(digit), e[k]);
                    check($sformatf("%s_p%0d", tag, k), int'(digit_pos),
                          tot - 1 - k);
                    check($sformatf("%s_l%0d", tag, k), int'(digit_last),
                          int'(k == tot - 1));
                    k++;
                end else begin
                    hold = 1'b1;
                    hd = int'(digit);
                    hp = int'(digit_pos);
                    hl = int'(digit_last);
                end
            end
            @(posedge clock); #1;
            cyc++;
        end
        digit_ready = 1'b0;
        check({tag, "_count"}, k, n);
        check({tag, "_lat"}, first, lat);
        if (n == tot) begin
            check({tag, "_end_valid"}, int'(digit_valid), 0);
            check({tag, "_end_ready"}, int'(value_ready), 1);
            check({tag, "_end_busy"}, int'(busy), 0);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_digit"}, int'(digit), 0);
        check({tag, "_valid"}, int'(digit_valid), 0);
        check({tag, "_pos"}, int'(digit_pos), 0);
        check({tag, "_last"}, int'(digit_last), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_vready"}, int'(value_ready), 1);
    endtask

    initial begin
        reset_n     = 1'b0;
        value       = '0;
        value_valid = 1'b0;
        digit_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outs("por");
        reset_n = 1'b1;
        @(posedge clock); #1;

        send(46);
`ifdef DIGIT_SPLITTER_LZ_BLANK_EN
        recv("v46", '{4, 6, 0, 0, 0}, 2, 2, 1'b0, 16);
`else
        recv("v46", '{0, 0, 0, 4, 6}, 5, 5, 1'b0, 16);
`endif

        send(327);
`ifdef DIGIT_SPLITTER_LZ_BLANK_EN
        recv("v327", '{3, 2, 7, 0, 0}, 3, 3, 1'b1, 16);
`else
        recv("v327", '{0, 0, 3, 2, 7}, 5, 5, 1'b1, 16);
`endif

        send(0);
`ifdef DIGIT_SPLITTER_LZ_BLANK_EN
        recv("v0", '{0, 0, 0, 0, 0}, 1, 1, 1'b0, 16);
`else
        recv("v0", '{0, 0, 0, 0, 0}, 5, 5, 1'b0, 16);
`endif

        send(65535);
        recv("vmax", '{6, 5, 5, 3, 5}, 5, 5, 1'b0, 16);

        send(12345);
        recv("v12345", '{1, 2, 3, 4, 5}, 5, 2, 1'b0, 16);
        check("mid_busy", int'(busy), 1);
        check("mid_pos", int'(digit_pos), 2);
        reset_n = 1'b0;
        #1;
        check_reset_outs("mid_rst");
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        send(9);
`ifdef DIGIT_SPLITTER_LZ_BLANK_EN
        recv("v9", '{9, 0, 0, 0, 0}, 1, 1, 1'b0, 16);
`else
        recv("v9", '{0, 0, 0, 0, 9}, 5, 5, 1'b0, 16);
`endif

        // value_valid stays high with a new value while the first is in flight
        value       = 16'd12;
        value_valid = 1'b1;
        @(posedge clock); #1;
        value = 16'd555;
        check("ovl_busy", int'(busy), 1);
        check("ovl_vready", int'(value_ready), 0);
`ifdef DIGIT_SPLITTER_LZ_BLANK_EN
        recv("v12", '{1, 2, 0, 0, 0}, 2, 2, 1'b0, 16);
`else
        recv("v12", '{0, 0, 0, 1, 2}, 5, 5, 1'b0, 16);
`endif
        @(posedge clock); #1;
        value_valid = 1'b0;
        check("ovl_accept_busy", int'(busy), 1);
`ifdef DIGIT_SPLITTER_LZ_BLANK_EN
        recv("v555", '{5, 5, 5, 0, 0}, 3, 3, 1'b0, 16);
`else
        recv("v555", '{0, 0, 5, 5, 5}, 5, 5, 1'b0, 16);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
        $fatal(1, "timeout");
    end

endmodule
